// File: rtl/lwe_pkg.sv
// -----------------------------------------------------------------------------
// lwe_pkg
// Shared definitions for the LWE encrypt/decrypt datapaths.
//   - LWE_DATA_WIDTH : default coefficient width (modulus q = 2^width)
//   - LWE_N_DIM      : default LWE dimension
//   - LWE_LANES      : coefficients carried per streaming beat
//   - lwe_state_e    : decryptor control states
//   - decode_bit()   : maps d to a plaintext bit from its top two bits
// -----------------------------------------------------------------------------
package lwe_pkg;

  localparam int LWE_DATA_WIDTH = 12;
  localparam int LWE_N_DIM      = 16;
  localparam int LWE_LANES      = 4;

  typedef enum logic [1:0] {
    ACC   = 2'd0,   // accepting ciphertext/key beats
    FINAL = 2'd1,   // one cycle: form d = v - <u,s> and decode
    OUT   = 2'd2    // hold result until the sink takes it
  } lwe_state_e;

  // d lies in [q/4, 3q/4) exactly when its top two bits are 01 or 10,
  // so the plaintext bit is their XOR.
  function automatic logic decode_bit(input logic [1:0] top2);
    return top2[1] ^ top2[0];
  endfunction

endpackage : lwe_pkg

// File: rtl/lwe_dot4.sv
// -----------------------------------------------------------------------------
// lwe_dot4
// Combinational 4-lane dot product mod 2^DATA_WIDTH.
//   i_u   : packed lanes {u3,u2,u1,u0}, u0 in the LSBs
//   i_s   : packed lanes {s3,s2,s1,s0}, same packing
//   o_dot : sum of u_k * s_k, every product and the sum truncated to
//           DATA_WIDTH bits
// -----------------------------------------------------------------------------
module lwe_dot4
  import lwe_pkg::*;
#(
  parameter int DATA_WIDTH = LWE_DATA_WIDTH
) (
  input  logic [LWE_LANES*DATA_WIDTH-1:0] i_u,
  input  logic [LWE_LANES*DATA_WIDTH-1:0] i_s,
  output logic [DATA_WIDTH-1:0]           o_dot
);

  logic [DATA_WIDTH-1:0] w_prod [LWE_LANES];

  // Keeping the product at DATA_WIDTH bits discards the high half, which is
  // exactly the mod-q reduction; no wider intermediate is needed.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first; a path that leaves it unassigned would infer a latch.
    o_dot = '0;
    for (int k = 0; k < LWE_LANES; k++) begin
      // NOTE: blocking assignments here, because each iteration reads the
      // running sum left by the previous one; sequential state uses <=.
      w_prod[k] = i_u[k*DATA_WIDTH +: DATA_WIDTH] * i_s[k*DATA_WIDTH +: DATA_WIDTH];
      o_dot     = o_dot + w_prod[k];
    end
  end

endmodule : lwe_dot4

// File: rtl/lwe_decryptor.sv
// -----------------------------------------------------------------------------
// lwe_decryptor
// Streaming LWE decryption: accepts N_DIM/4 beats of ciphertext u and key s,
// computes d = v - <u,s> mod 2^DATA_WIDTH and decodes one plaintext bit.
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready : beat handshake (in_ready high only in ACC)
//   in_u, in_s          : 4 packed lanes each, lane 0 in the LSBs
//   in_v                : ciphertext scalar, taken on the first beat only
//   out_valid/out_ready : result handshake
//   out_bit, out_raw    : decoded bit and d, stable while out_valid is high
//   busy                : high unless idle in ACC at beat 0
// -----------------------------------------------------------------------------
module lwe_decryptor
  import lwe_pkg::*;
#(
  parameter int DATA_WIDTH = LWE_DATA_WIDTH,
  parameter int N_DIM      = LWE_N_DIM
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [LWE_LANES*DATA_WIDTH-1:0] in_u,
  input  logic [LWE_LANES*DATA_WIDTH-1:0] in_s,
  input  logic [DATA_WIDTH-1:0]           in_v,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_bit,
  output logic [DATA_WIDTH-1:0]           out_raw,
  output logic                            busy
);

  localparam int BEATS = N_DIM / LWE_LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  lwe_state_e            r_state;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_v;
  logic                  r_out_valid;
  logic                  r_out_bit;
  logic [DATA_WIDTH-1:0] r_out_raw;

  logic [DATA_WIDTH-1:0] w_dot;
  logic [DATA_WIDTH-1:0] w_diff;
  logic                  w_beat;

  lwe_dot4 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_dot4 (
    .i_u   (in_u),
    .i_s   (in_s),
    .o_dot (w_dot)
  );

  // in_ready and busy decode only the state register, so out_ready never
  // reaches in_ready combinationally.
  assign in_ready  = (r_state == ACC);
  assign busy      = !((r_state == ACC) && (r_cnt == '0));
  assign w_beat    = in_valid && in_ready;
  assign w_diff    = r_v - r_acc;

  assign out_valid = r_out_valid;
  assign out_bit   = r_out_bit;
  assign out_raw   = r_out_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ACC;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_v         <= '0;
      r_out_valid <= 1'b0;
      r_out_bit   <= 1'b0;
      r_out_raw   <= '0;
    end else begin
      case (r_state)
        ACC: begin
          if (w_beat) begin
            // Beat 0 overwrites acc and v, so a stale partial sum never leaks
            // into the next ciphertext.
            if (r_cnt == '0) begin
              r_acc <= w_dot;
              r_v   <= in_v;
            end else begin
              r_acc <= r_acc + w_dot;
            end
            if (r_cnt == LAST_BEAT) begin
              r_cnt   <= '0;
              r_state <= FINAL;
            end else begin
              r_cnt   <= r_cnt + CW'(1);
            end
          end
        end
        FINAL: begin
          r_out_raw   <= w_diff;
          r_out_bit   <= decode_bit(w_diff[DATA_WIDTH-1 -: 2]);
          r_out_valid <= 1'b1;
          r_state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ACC;
          end
        end
        default: r_state <= ACC;
      endcase
    end
  end

endmodule : lwe_decryptor
